// File: rtl/calculator_stack_unit.sv
// calculator_stack_unit
// ----------------------------------------------------------------------------
// Accumulator calculator with an undo history. One operation runs per Enter
// press. MUL is an iterative shift-add that takes WIDTH cycles. Every other
// operation completes on the edge that accepts it.
//
// Ports
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset
//   NumIn     operand N (sampled only on the accept edge)
//   OpIn      opcode: 000 ADD, 001 SUB, 010 OR, 011 EQ,
//                     100 AND, 101 XOR, 110 MUL, 111 UNDO
//   Enter     operation request. Level-sensitive, and re-armed only after it
//             has been released.
//   NumOut    accumulator value
//   Busy      high while a multiply is in progress
//   Carry     carry/borrow/overflow of the last completed op
//   Zero      last completed result was zero
//   Err       last op was UNDO on an empty history
//   StackCnt  number of valid history entries
//
// Handshake: a request is taken on the first rising edge in IDLE that sees
// Enter=1. The FSM then parks in RELEASE until Enter is seen low. A held
// Enter therefore produces exactly one operation.
// ----------------------------------------------------------------------------
module calculator_stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           NumIn,
  input  logic [2:0]                 OpIn,
  input  logic                       Enter,
  output logic [WIDTH-1:0]           NumOut,
  output logic                       Busy,
  output logic                       Carry,
  output logic                       Zero,
  output logic                       Err,
  output logic [$clog2(DEPTH+1)-1:0] StackCnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_EQ   = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_UNDO = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_RELEASE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   hist [DEPTH];
  logic [PW-1:0]      wr_ptr;   // next slot to write; the top of the history is one below it
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [2*WIDTH-1:0] mul_prod;
  logic [KW-1:0]      mul_step;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [WIDTH:0]     add_full;
  logic [PW-1:0]      ptr_next;
  logic [PW-1:0]      ptr_prev;
  logic [WIDTH-1:0]   hist_top;
  logic [2*WIDTH-1:0] prod_next;

  // Single-cycle ALU. N is the left-hand operand throughout, so SUB is N-A.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    add_full  = {1'b0, NumIn} + {1'b0, acc};
    case (OpIn)
      OP_ADD: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
      end
      OP_SUB: begin
        alu_res   = NumIn - acc;
        alu_carry = (NumIn < acc);
      end
      OP_OR:   alu_res = NumIn | acc;
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (NumIn == acc)};
      OP_AND:  alu_res = NumIn & acc;
      OP_XOR:  alu_res = NumIn ^ acc;
      default: alu_res = acc;
    endcase
  end

  // The history pointer wraps explicitly, so that a DEPTH which is not a
  // power of two still behaves as a circular buffer.
  always_comb begin
    ptr_next  = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    ptr_prev  = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
    hist_top  = hist[ptr_prev];
    // The shift-add step for this cycle. On the last step this is the final product.
    prod_next = mul_prod + (mul_mplier[0] ? mul_mcand : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      Busy       <= 1'b0;
      Carry      <= 1'b0;
      Zero       <= 1'b0;
      Err        <= 1'b0;
      wr_ptr     <= '0;
      cnt        <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_prod   <= '0;
      mul_step   <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Enter) begin
            if (OpIn == OP_MUL) begin
              mul_mcand  <= {{WIDTH{1'b0}}, NumIn};
              mul_mplier <= acc;
              mul_prod   <= '0;
              mul_step   <= '0;
              Busy       <= 1'b1;
              state      <= S_MULT;
            end else if (OpIn == OP_UNDO) begin
              Carry <= 1'b0;
              state <= S_RELEASE;
              if (cnt == '0) begin
                Err  <= 1'b1;
                Zero <= (acc == '0);
              end else begin
                acc    <= hist_top;
                wr_ptr <= ptr_prev;
                cnt    <= cnt - 1'b1;
                Err    <= 1'b0;
                Zero   <= (hist_top == '0);
              end
            end else begin
              acc          <= alu_res;
              Carry        <= alu_carry;
              Zero         <= (alu_res == '0);
              Err          <= 1'b0;
              hist[wr_ptr] <= acc;
              wr_ptr       <= ptr_next;
              if (cnt != CW'(DEPTH)) cnt <= cnt + 1'b1;
              state        <= S_RELEASE;
            end
          end
        end
        S_MULT: begin
          mul_prod   <= prod_next;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_step   <= mul_step + 1'b1;
          if (mul_step == KW'(WIDTH - 1)) begin
            // The accumulator still holds the pre-op value here, so it is
            // the correct entry to push.
            acc          <= prod_next[WIDTH-1:0];
            Carry        <= |prod_next[2*WIDTH-1:WIDTH];
            Zero         <= (prod_next[WIDTH-1:0] == '0);
            Err          <= 1'b0;
            hist[wr_ptr] <= acc;
            wr_ptr       <= ptr_next;
            if (cnt != CW'(DEPTH)) cnt <= cnt + 1'b1;
            Busy         <= 1'b0;
            state        <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!Enter) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign NumOut   = acc;
  assign StackCnt = cnt;

endmodule

// File: tb/tb_calculator_stack_unit.sv
// tb_calculator_stack_unit
// ----------------------------------------------------------------------------
// Directed testbench for calculator_stack_unit (WIDTH=8, DEPTH=4). Every
// expected value in this file was computed by hand. All comparisons go
// through check_eq.
// ----------------------------------------------------------------------------
module tb_calculator_stack_unit;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_EQ   = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_UNDO = 3'b111;

  logic       clk;
  logic       rst_n;
  logic [7:0] num_in;
  logic [2:0] op_in;
  logic       enter;
  logic [7:0] num_out;
  logic       busy;
  logic       carry;
  logic       zero;
  logic       err;
  logic [2:0] stack_cnt;

  int n_checks;
  int n_errors;

  calculator_stack_unit #(.WIDTH(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .NumIn    (num_in),
    .OpIn     (op_in),
    .Enter    (enter),
    .NumOut   (num_out),
    .Busy     (busy),
    .Carry    (carry),
    .Zero     (zero),
    .Err      (err),
    .StackCnt (stack_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checker
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks. Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enter  = 1'b0;
    op_in  = OP_ADD;
    num_in = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // A single-cycle op: press for one edge, release, and let RELEASE return to IDLE.
  task automatic op_single(input logic [2:0] op, input logic [7:0] n);
    op_in  = op;
    num_in = n;
    enter  = 1'b1;
    tick();
    enter  = 1'b0;
    tick();
  endtask

  // A multiply. Returns the number of sampled cycles with Busy high. The
  // hold flag keeps Enter high for the whole multiply.
  task automatic op_mul(input logic [7:0] n, input bit hold,
                        input logic [7:0] acc_before, input logic [2:0] cnt_before,
                        output int busy_cycles);
    op_in  = OP_MUL;
    num_in = n;
    enter  = 1'b1;
    tick();
    if (!hold) enter = 1'b0;
    // These inputs must be ignored during MULT.
    op_in  = OP_ADD;
    num_in = 8'hFF;
    busy_cycles = busy ? 1 : 0;
    check_eq("mul_numout_held", num_out, acc_before);
    check_eq("mul_cnt_held", stack_cnt, cnt_before);
    while (busy && busy_cycles < 50) begin
      tick();
      if (busy) busy_cycles++;
    end
    enter = 1'b0;
    tick();
  endtask

  // Stimulus
  int bc;
  logic [7:0] undo_exp [4];
  logic [2:0] undo_cnt [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    undo_exp[0] = 8'd10; undo_exp[1] = 8'd6; undo_exp[2] = 8'd3; undo_exp[3] = 8'd1;
    undo_cnt[0] = 3'd3;  undo_cnt[1] = 3'd2; undo_cnt[2] = 3'd1; undo_cnt[3] = 3'd0;

    // Reset state
    rst_n  = 1'b0;
    enter  = 1'b0;
    op_in  = OP_ADD;
    num_in = '0;
    tick();
    check_eq("rst_numout", num_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_carry", carry, 0);
    check_eq("rst_zero", zero, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_cnt", stack_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Accumulate: a held Enter gives exactly one ADD
    op_in  = OP_ADD;
    num_in = 8'd5;
    enter  = 1'b1;
    tick();
    check_eq("hold_add_first", num_out, 5);
    check_eq("hold_add_cnt_first", stack_cnt, 1);
    for (int i = 0; i < 4; i++) tick();
    check_eq("hold_add_stays", num_out, 5);
    check_eq("hold_add_cnt_stays", stack_cnt, 1);
    enter = 1'b0;
    tick();
    op_single(OP_ADD, 8'd5);
    check_eq("add_second", num_out, 10);
    check_eq("add_second_cnt", stack_cnt, 2);
    check_eq("add_second_carry", carry, 0);

    // SUB with borrow: 3 - 10 = 249
    op_single(OP_SUB, 8'd3);
    check_eq("sub_result", num_out, 249);
    check_eq("sub_borrow", carry, 1);
    check_eq("sub_zero", zero, 0);
    check_eq("sub_cnt", stack_cnt, 3);

    // ADD with carry-out: 200 + 100 = 300 -> 44
    do_reset();
    op_single(OP_ADD, 8'd200);
    op_single(OP_ADD, 8'd100);
    check_eq("add_wrap", num_out, 44);
    check_eq("add_carry", carry, 1);

    // MUL: 20 * 13 = 260 -> 4, overflow
    do_reset();
    op_single(OP_ADD, 8'd20);
    op_mul(8'd13, 1'b0, 8'd20, 3'd1, bc);
    check_eq("mul_busy_cycles", bc, 8);
    check_eq("mul_result", num_out, 4);
    check_eq("mul_carry", carry, 1);
    check_eq("mul_zero", zero, 0);
    check_eq("mul_cnt", stack_cnt, 2);
    check_eq("mul_busy_low", busy, 0);
    // MUL by zero, with Enter held through the multiply
    op_mul(8'd0, 1'b1, 8'd4, 3'd2, bc);
    check_eq("mul0_busy_cycles", bc, 8);
    check_eq("mul0_result", num_out, 0);
    check_eq("mul0_zero", zero, 1);
    check_eq("mul0_carry", carry, 0);
    check_eq("mul0_cnt", stack_cnt, 3);
    // MUL without overflow: 15 * 17 = 255
    op_single(OP_ADD, 8'd15);
    op_mul(8'd17, 1'b0, 8'd15, 3'd4, bc);
    check_eq("mul255_result", num_out, 255);
    check_eq("mul255_carry", carry, 0);

    // History: ADD 1..5 pushes 0,1,3,6,10. The oldest entry (0) is overwritten.
    do_reset();
    for (int i = 1; i <= 5; i++) op_single(OP_ADD, 8'(i));
    check_eq("hist_acc", num_out, 15);
    check_eq("hist_cnt_full", stack_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      op_single(OP_UNDO, 8'd0);
      check_eq("undo_value", num_out, undo_exp[i]);
      check_eq("undo_cnt", stack_cnt, undo_cnt[i]);
      check_eq("undo_err", err, 0);
    end
    op_single(OP_UNDO, 8'd0);
    check_eq("undo_empty_value", num_out, 1);
    check_eq("undo_empty_err", err, 1);
    check_eq("undo_empty_cnt", stack_cnt, 0);
    check_eq("undo_empty_carry", carry, 0);
    op_single(OP_ADD, 8'd2);
    check_eq("err_cleared_value", num_out, 3);
    check_eq("err_cleared", err, 0);

    // EQ and the logic ops
    do_reset();
    op_single(OP_ADD, 8'd7);
    op_single(OP_EQ, 8'd7);
    check_eq("eq_true", num_out, 1);
    check_eq("eq_carry", carry, 0);
    op_single(OP_XOR, 8'd3);
    check_eq("xor_result", num_out, 2);
    op_single(OP_EQ, 8'd5);
    check_eq("eq_false", num_out, 0);
    op_single(OP_OR, 8'd5);
    check_eq("or_result", num_out, 5);
    check_eq("or_zero", zero, 0);
    op_single(OP_AND, 8'd0);
    check_eq("and_result", num_out, 0);
    check_eq("and_zero", zero, 1);

    // Reset asserted in the 4th MULT cycle
    do_reset();
    op_single(OP_ADD, 8'd20);
    op_in  = OP_MUL;
    num_in = 8'd13;
    enter  = 1'b1;
    tick();
    enter = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_numout", num_out, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_cnt", stack_cnt, 0);
    check_eq("abort_carry", carry, 0);
    tick();
    rst_n = 1'b1;
    tick();
    op_single(OP_ADD, 8'd9);
    check_eq("post_abort_add", num_out, 9);
    check_eq("post_abort_cnt", stack_cnt, 1);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calculator_stack_unit.md
# calculator_stack_unit

Parametrised accumulator calculator that replaces the fixed 8-bit, 4-operation calculator in the chip top. It keeps a WIDTH-bit accumulator and applies one of eight operations per Enter press, including an iterative multiply. A DEPTH-entry undo history and registered status flags are added. The block sits between the chip's input pins (NumIn/OpIn/Enter) and the output pins (NumOut/status).

## Interface
- WIDTH, default 8: operand, accumulator and NumOut width (≥2).
- DEPTH, default 4: undo-history entries (≥1).
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- NumIn  in  WIDTH  operand.
- OpIn  in  3  opcode:
  - 000 ADD, 001 SUB, 010 OR, 011 EQ
  - 100 AND, 101 XOR, 110 MUL, 111 UNDO
- Enter  in  1  operation request, level-sensitive, re-armed only after release.
- NumOut  out  WIDTH  accumulator value.
- Busy  out  1  high while a multiply is in progress.
- Carry  out  1  carry/borrow/overflow of the last completed op.
- Zero  out  1  last completed result == 0.
- Err  out  1  last op was UNDO with an empty history.
- StackCnt  out  $clog2(DEPTH+1)  number of valid history entries.

## Operation
- Reset (async, rst_n=0):
  - accumulator, all flags, Busy and StackCnt go to 0.
  - History is emptied.
  - FSM enters IDLE.
- FSM states: IDLE, MULT, RELEASE.
- IDLE, Enter=0: hold.
- IDLE, Enter=1: operation accepted on this edge. OpIn and NumIn are sampled here only.
  - Single-cycle ops: result written to accumulator on the accept edge; go to RELEASE.
  - MUL: latch multiplicand and multiplier, clear partial product and bit counter; go to MULT.
- MULT: one shift-add step per cycle for WIDTH cycles.
  - On the WIDTH-th step, write the low WIDTH bits to the accumulator and go to RELEASE.
  - Enter, OpIn and NumIn are ignored.
- RELEASE: stay while Enter=1; go to IDLE on the first cycle Enter=0.
- Result definitions, with A = accumulator before the op and N = NumIn:
  - ADD: N+A mod 2^WIDTH; Carry = carry-out.
  - SUB: N−A mod 2^WIDTH; Carry = 1 when N<A (borrow).
  - OR / AND / XOR: bitwise N op A; Carry = 0.
  - EQ: result 1 if N==A, else 0; Carry = 0.
  - MUL: low WIDTH bits of N×A; Carry = 1 when the high WIDTH bits of the 2·WIDTH product are nonzero.
  - UNDO, non-empty history: accumulator ← most recent entry; pop; Carry = 0; Err = 0.
  - UNDO, empty history: accumulator unchanged; Carry = 0; Err = 1.
- Zero = (new accumulator == 0). It is written together with Carry/Err on every completed op.
- Err clears on any completed non-failing op.
- History push:
  - Every accepted non-UNDO op pushes A.
  - For MUL, the push happens at completion, not at accept.
  - When full (StackCnt==DEPTH), the push discards the oldest entry and StackCnt stays DEPTH (circular overwrite).
- Flags and NumOut change only at op completion; they hold otherwise.

## Timing
- Single-cycle ops: NumOut and flags are valid after the accept edge (latency 1 edge from Enter sampled high).
- MUL:
  - Busy rises after the accept edge and stays high for exactly WIDTH cycles.
  - NumOut, flags and StackCnt update on the edge at which Busy falls: WIDTH edges after accept.
- Holding Enter high produces exactly one operation. The next op needs at least one cycle with Enter=0, then Enter=1.
- Minimum op spacing: 2 cycles for single-cycle ops, WIDTH+2 cycles for MUL.
- Enter dropped during MULT: the multiply still completes; RELEASE exits on the next cycle.
- Reset asserted mid-multiply aborts immediately: no partial result, no push, Busy=0.

## Test plan
- Accumulate (WIDTH=8, DEPTH=4):
  - After reset, Enter=1 held 5 cycles with ADD, N=5 → NumOut=5 after one edge and stays 5; StackCnt=1.
  - Release, then press ADD N=5 again → NumOut=10.
- SUB borrow: A=10, SUB N=3 → NumOut=249, Carry=1, Zero=0.
- MUL: A=20, MUL N=13 → Busy high 8 cycles, then NumOut=4 (260 mod 256), Carry=1.
  - Then A=4, MUL N=0 → NumOut=0, Zero=1, Carry=0.
- History: from reset, do ADD 1, 2, 3, 4, 5 (A=15, StackCnt=4), then 5× UNDO:
  - Successive values 10, 6, 3, 1.
  - 5th UNDO: NumOut=1, Err=1, StackCnt=0.
- EQ and logic:
  - A=7, EQ N=7 → 1.
  - Then XOR N=3 → 2.
  - Then AND N=0 → 0, Zero=1.
- Reset mid-MUL: assert rst_n=0 on the 4th MULT cycle → all outputs 0 immediately; after release the block accepts an ADD N=9 → NumOut=9.
